// File: rtl/kgp_clk_pkg.sv
// ----------------------------------------------------------------------------
// kgp_clk_pkg
//
// Purpose : Shared constants and types for the KGP_RISC clock-enable
//           scheduler. The phase-qualified datapath of the core imports the
//           same package, so phase indices and the phase count stay in one
//           place.
//
// Contents: DIV_W / DIV_DEFAULT / NUM_PHASES defaults, sequencer state
//           encoding, phase index constants PH_IF..PH_WB and a phase
//           increment helper.
// ----------------------------------------------------------------------------
package kgp_clk_pkg;

    localparam int DIV_W       = 4;
    localparam int DIV_DEFAULT = 8;
    localparam int NUM_PHASES  = 5;
    localparam int PHASE_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

    localparam logic [PHASE_W-1:0] PH_IF  = 3'd0;
    localparam logic [PHASE_W-1:0] PH_ID  = 3'd1;
    localparam logic [PHASE_W-1:0] PH_EX  = 3'd2;
    localparam logic [PHASE_W-1:0] PH_MEM = 3'd3;
    localparam logic [PHASE_W-1:0] PH_WB  = 3'd4;

    // Next phase index, wrapping from n_phases-1 back to PH_IF.
    function automatic logic [PHASE_W-1:0] next_phase(
        input logic [PHASE_W-1:0] ph,
        input int                 n_phases
    );
        if (ph == PHASE_W'(n_phases - 1)) begin
            return PH_IF;
        end
        return ph + 1'b1;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// ----------------------------------------------------------------------------
// tick_counter
//
// Purpose : Divide counter for the phase sequencer. Counts 0..div_act and
//           wraps. Holds the active divide ratio and a shadow copy so that a
//           ratio written while the core is running only takes effect at the
//           next wrap, never truncating a period in progress.
//
// Ports   :
//   clock      in   system clock
//   resetn     in   asynchronous active-low reset
//   i_hold     in   sequencer is idle: counter held at 0, writes load directly
//   i_cfg_wr   in   one-cycle strobe loading i_cfg_div
//   i_cfg_div  in   new divide ratio (0 = wrap every cycle)
//   o_cnt      out  current count
//   o_wrap     out  count has reached div_act (last cycle of the period)
// ----------------------------------------------------------------------------
module tick_counter
    import kgp_clk_pkg::*;
#(
    parameter int DIV_W       = kgp_clk_pkg::DIV_W,
    parameter int DIV_DEFAULT = kgp_clk_pkg::DIV_DEFAULT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_hold,
    input  logic             i_cfg_wr,
    input  logic [DIV_W-1:0] i_cfg_div,
    output logic [DIV_W-1:0] o_cnt,
    output logic             o_wrap
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_div_shadow;
    logic [DIV_W-1:0] w_div_reload;

    assign o_cnt  = r_cnt;
    assign o_wrap = (r_cnt == r_div_act);

    // A write landing in the wrap cycle itself is the latest write before
    // the wrap, so it bypasses the shadow and is used straight away.
    assign w_div_reload = i_cfg_wr ? i_cfg_div : r_div_shadow;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= '0;
            r_div_act    <= DIV_W'(DIV_DEFAULT);
            r_div_shadow <= DIV_W'(DIV_DEFAULT);
        end else if (i_hold) begin
            r_cnt <= '0;
            if (i_cfg_wr) begin
                r_div_act    <= i_cfg_div;
                r_div_shadow <= i_cfg_div;
            end
        end else begin
            if (i_cfg_wr) begin
                r_div_shadow <= i_cfg_div;
            end
            if (o_wrap) begin
                r_cnt     <= '0;
                r_div_act <= w_div_reload;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// ----------------------------------------------------------------------------
// phase_sequencer
//
// Purpose : Clock-enable scheduler for the KGP_RISC core. Generates a divided
//           tick and a one-hot five-phase strobe (IF, ID, EX, MEM, WB) from
//           the system clock, with run / halt / single-step control that acts
//           on instruction boundaries. No clocks are derived here; downstream
//           logic stays on `clock` and qualifies updates with `phase_en`.
//
// Handshake: run and halt_req are levels sampled every clock; step_req is a
//           pulse honoured only in IDLE. step_ack / instr_done / tick are
//           single-cycle pulses. All outputs decode registered state only.
//
// Ports   :
//   clock       in   system clock
//   resetn      in   asynchronous active-low reset
//   cfg_wr      in   strobe loading cfg_div
//   cfg_div     in   divide ratio, tick period is cfg_div+1 clocks
//   run         in   free-run while high
//   halt_req    in   stop at next instruction boundary
//   step_req    in   run exactly one instruction from IDLE
//   step_ack    out  pulse when the stepped instruction completes
//   halted      out  high while IDLE
//   tick        out  one-cycle enable at the end of each divided period
//   phase       out  current phase index
//   phase_en    out  tick decoded by phase (one-hot or zero)
//   instr_done  out  tick in the last phase
//   dbg_state   out  current sequencer state encoding
// ----------------------------------------------------------------------------
module phase_sequencer
    import kgp_clk_pkg::*;
#(
    parameter int DIV_W       = kgp_clk_pkg::DIV_W,
    parameter int DIV_DEFAULT = kgp_clk_pkg::DIV_DEFAULT,
    parameter int NUM_PHASES  = kgp_clk_pkg::NUM_PHASES
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  cfg_wr,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic                  run,
    input  logic                  halt_req,
    input  logic                  step_req,
    output logic                  step_ack,
    output logic                  halted,
    output logic                  tick,
    output logic [2:0]            phase,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  instr_done,
    output logic [1:0]            dbg_state
);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [2:0]       r_phase;
    logic [2:0]       w_phase_nxt;

    logic [DIV_W-1:0] w_cnt;
    logic             w_wrap;
    logic             w_idle;
    logic             w_tick;
    logic             w_instr_done;
    logic             w_at_boundary;
    logic             w_stop_req;

    assign w_idle = (r_state == ST_IDLE);

    tick_counter #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_tick_counter (
        .clock     (clock),
        .resetn    (resetn),
        .i_hold    (w_idle),
        .i_cfg_wr  (cfg_wr),
        .i_cfg_div (cfg_div),
        .o_cnt     (w_cnt),
        .o_wrap    (w_wrap)
    );

    assign w_tick       = w_wrap & ~w_idle;
    assign w_instr_done = w_tick & (r_phase == 3'(NUM_PHASES - 1));
    assign w_stop_req   = ~run | halt_req;

    // Nothing of the current instruction has been issued yet: start of the
    // first period and no tick this cycle (with a divide of 0 the very first
    // cycle already carries the IF tick, so it is not a clean boundary).
    assign w_at_boundary = (w_cnt == '0) && (r_phase == PH_IF) && !w_tick;

    // ------------------------------------------------------------------
    // State and phase registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_phase <= PH_IF;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // halt_req > run > step_req
                if (!halt_req) begin
                    if (run) begin
                        w_state_nxt = ST_RUN;
                    end else if (step_req) begin
                        w_state_nxt = ST_STEP;
                    end
                end
            end
            ST_RUN: begin
                if (w_stop_req) begin
                    // Stopping on the completing tick or before anything was
                    // issued needs no drain.
                    if (w_at_boundary || w_instr_done) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_STEP: begin
                if (w_instr_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_instr_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase advance: one step per tick, parked at IF while idle. A divide
    // change only affects the counter, never the phase.
    // ------------------------------------------------------------------
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_idle) begin
            w_phase_nxt = PH_IF;
        end else if (w_tick) begin
            w_phase_nxt = next_phase(r_phase, NUM_PHASES);
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        phase_en = '0;
        if (w_tick) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (r_phase == 3'(i)) begin
                    phase_en[i] = 1'b1;
                end
            end
        end
    end

    assign tick       = w_tick;
    assign instr_done = w_instr_done;
    assign step_ack   = w_instr_done & (r_state == ST_STEP);
    assign halted     = w_idle;
    assign phase      = r_phase;
    assign dbg_state  = r_state;

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Programmable clock-enable scheduler for the KGP_RISC core. From the single system clock it generates a divided `tick` and a one-hot five-phase strobe: IF, ID, EX, MEM, WB. A run/halt/single-step control interface lets the debug or top-level controller start, stop and step the core on instruction boundaries. All downstream logic stays on `clock` and qualifies its updates with `phase_en`; no derived clocks leave this block.

## Interface
- `DIV_W`, 4: width of the divide-ratio field.
- `DIV_DEFAULT`, 8: divide ratio after reset. The tick period is `DIV_DEFAULT+1` clocks.
- `NUM_PHASES`, 5: phases per instruction.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `cfg_wr`  in  1  one-cycle strobe that loads `cfg_div`.
- `cfg_div`  in  DIV_W  new divide ratio; 0 means a tick every cycle.
- `run`  in  1  level; free-run while high.
- `halt_req`  in  1  level; stop at the next instruction boundary.
- `step_req`  in  1  pulse; execute exactly one instruction from halt.
- `step_ack`  out  1  one-cycle pulse when the stepped instruction completes.
- `halted`  out  1  high while in IDLE.
- `tick`  out  1  one-cycle enable at the end of each divided period.
- `phase`  out  3  current phase index, 0..NUM_PHASES-1.
- `phase_en`  out  NUM_PHASES  one-hot strobe, equal to `tick` decoded by `phase`.
- `instr_done`  out  1  pulse coinciding with `phase_en[NUM_PHASES-1]`.

## Operation
- **States:** IDLE, RUN, STEP, DRAIN.
- **Divide counter** (`cnt`):
  - Counts 0..`div_act`, then wraps to 0.
  - Held at 0 in IDLE.
  - `tick` = (`cnt == div_act`) and state is not IDLE.
- **Phase sequencing:**
  - `phase` advances on every tick and wraps from NUM_PHASES-1 to 0.
  - `instr_done` fires on the tick in phase NUM_PHASES-1.
- **State transitions:**
  - IDLE → RUN when `run` is high and `halt_req` is low.
  - IDLE → STEP when `step_req` is high and `run` and `halt_req` are low.
  - RUN → DRAIN when `run` falls or `halt_req` rises.
  - RUN → IDLE directly if that event occurs while `cnt == 0` and `phase == 0`.
  - DRAIN → IDLE on `instr_done`.
  - STEP → IDLE on `instr_done`; `step_ack` pulses in that same cycle.
- **Priority** when requests coincide in IDLE: `halt_req` > `run` > `step_req`.
- **Ignored requests:**
  - `step_req` is ignored outside IDLE.
  - In DRAIN, a re-asserted `run` is ignored until IDLE is reached.
- **Divide configuration:**
  - `cfg_wr` in IDLE loads `div_act` immediately.
  - In any other state the value goes to `div_shadow` and becomes `div_act` on the next counter wrap, so a period is never truncated.
  - Of back-to-back writes, the last one before the wrap wins.
- **Reset** (`resetn` low, asynchronous):
  - State IDLE, `cnt`=0, `phase`=0.
  - `div_act` = `div_shadow` = DIV_DEFAULT.
  - `halted`=1; `tick`, `phase_en`, `instr_done`, `step_ack` = 0.
  - A reset mid-instruction abandons the instruction with no `instr_done` or `step_ack`.

## Timing
- All outputs are decoded from registers only; there are no combinational input-to-output paths.
- The state register updates one clock after `run` or `step_req` is sampled.
- The first `tick` comes `div_act+1` clocks after entering RUN or STEP.
- Example, `div_act`=8:
  - `run` sampled at edge 0.
  - RUN entered from edge 1.
  - `phase_en[0]` high in cycle 9.
  - `instr_done` in cycle 45.
- One instruction takes `NUM_PHASES*(div_act+1)` clocks.
- `halted` rises one clock after `instr_done` in DRAIN or STEP.
- A `div_act` change does not reset `phase`.
- With `div_act`=0, `tick` is high every cycle in non-IDLE states.

## Structure
- **Shared package `kgp_clk_pkg`:**
  - State encoding constants.
  - Phase index constants `PH_IF`..`PH_WB`.
  - `NUM_PHASES` and `DIV_DEFAULT`, reused by the core's phase-qualified datapath.
- **Sub-module `tick_counter`:**
  - Holds `cnt`, `div_act` and `div_shadow`.
  - Implements reload-on-wrap.
  - Produces `wrap`.
- The FSM, phase register and output decode live in `phase_sequencer`.

## Test plan
- **Reset/run:** reset, then `run`=1 with the default divide. `phase_en` cycles 1,2,4,8,16 at cycles 9,18,27,36,45; `instr_done` at cycle 45; `halted` is 0 from cycle 1.
- **Single step:** from IDLE, pulse `step_req`. Exactly 5 ticks, then `step_ack` at tick 5, then `halted`=1 one clock later. A second `step_req` during STEP is ignored.
- **Drain:** drop `run` during phase 2. Phases 3 and 4 still fire, then IDLE. Dropping `run` at `cnt`=0 with `phase`=0 goes to IDLE on the next clock with no extra tick.
- **Reconfigure:** write `cfg_div`=2 mid-period while running with div 8. The current period stays 9 clocks and subsequent periods are 3. Writing `cfg_div`=0 gives `tick` every cycle.
- **Priority:** assert `run`, `step_req` and `halt_req` together in IDLE; the block stays IDLE. Release `halt_req`; RUN is entered with no `step_ack`.
- **Async reset:** pull `resetn` low in phase 3, asynchronous to `clock`. Outputs clear immediately and `div_act` returns to 8.
